// File: rtl/alu_result_out_fifo.sv
// Output stage for the dual ALU: queues {res1,res0} result pairs and presents one
// word at a time on the user GPIOs, host-paced (synchronised adv) or timed (auto_mode).
module alu_result_out_fifo #(
  parameter int RES_W       = 7,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clock,
  input  logic                     resetb,
  input  logic                     in_valid,
  input  logic [RES_W-1:0]         in_res0,
  input  logic [RES_W-1:0]         in_res1,
  output logic                     in_ready,
  input  logic                     auto_mode,
  input  logic                     adv,
  input  logic                     clr,
  output logic [2*RES_W:0]         io_out,
  output logic [2*RES_W:0]         io_oeb,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     underrun,
  output logic [7:0]               words_shown
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int WW = 2 * RES_W;
  localparam int OW = 2 * RES_W + 1;
  localparam logic [AW:0]   C_FULL  = (AW+1)'(DEPTH);
  localparam logic [HW-1:0] C_HOLD1 = HW'(HOLD_CYCLES - 1);

  typedef enum logic {S_IDLE, S_SHOW} state_t;

  logic [WW-1:0]          r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_count;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_adv_prev;
  logic [HW-1:0]          r_hold;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [OW-1:0]          r_io_out;
  logic [OW-1:0]          r_io_oeb;
  logic                   r_underrun;
  logic [7:0]             r_words;

  logic w_ready;
  logic w_push;
  logic w_nonempty;
  logic w_adv_pulse;
  logic w_hold_zero;
  logic w_present;
  logic w_hold_dec;

  // Handshake decisions come from registered occupancy only
  assign w_ready     = (r_count != C_FULL);
  assign w_push      = in_valid & w_ready;
  assign w_nonempty  = (r_count != '0);
  assign w_adv_pulse = r_sync[SYNC_STAGES-1] & ~r_adv_prev;
  assign w_hold_zero = (r_hold == '0);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_sync     <= '0;
      r_adv_prev <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], adv};
      r_adv_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_nonempty && (auto_mode || w_adv_pulse)) w_state_nxt = S_SHOW;
      S_SHOW:  if (auto_mode && w_hold_zero && !w_nonempty) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Manual mode in SHOW leaves hold_cnt frozen so a later switch to auto resumes it
  always_comb begin
    w_present  = 1'b0;
    w_hold_dec = 1'b0;
    case (r_state)
      S_IDLE: w_present = w_nonempty && (auto_mode || w_adv_pulse);
      S_SHOW: begin
        if (auto_mode) begin
          w_hold_dec = !w_hold_zero;
          w_present  = w_hold_zero && w_nonempty;
        end else begin
          w_present  = w_adv_pulse && w_nonempty;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_res1, in_res0};
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)    r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_present) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_present})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Bit 0 flips on every presented word so repeated values are still visible
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_io_out <= '0;
      r_io_oeb <= '1;
      r_hold   <= '0;
    end else begin
      if (w_present) begin
        r_io_out <= {r_mem[r_rd_ptr], ~r_io_out[0]};
        r_io_oeb <= '0;
        if (auto_mode) r_hold <= C_HOLD1;
      end else if (w_hold_dec) begin
        r_hold <= r_hold - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_underrun <= 1'b0;
      r_words    <= '0;
    end else if (clr) begin
      r_underrun <= 1'b0;
      r_words    <= '0;
    end else begin
      if (w_adv_pulse && !w_nonempty) r_underrun <= 1'b1;
      if (w_present)                  r_words    <= r_words + 8'd1;
    end
  end

  assign in_ready    = w_ready;
  assign io_out      = r_io_out;
  assign io_oeb      = r_io_oeb;
  assign count       = r_count;
  assign underrun    = r_underrun;
  assign words_shown = r_words;

endmodule
